led_blinker: RTL and testbench
==============================

# led_blinker

Command-driven LED output controller: it accepts a mode command over a valid/ready handshake and drives one LED as steady off, steady on, continuous blink, or a finite burst of N blinks. It is the output-side counterpart to the switch edge-detect/toggle logic. Switch or button events, or any other control logic, issue commands, and this block owns all LED timing. It sits between board-level control logic and the LED pin.

## Interface
Parameters:
- TICK_DIV, 50000: clk cycles per tick (1 ms at 50 MHz); must be ≥ 2.
- ON_TICKS, 250: ticks LED is lit per blink phase; must be ≥ 1.
- OFF_TICKS, 250: ticks LED is dark per blink phase; must be ≥ 1.
- CNT_W, 4: width of burst count.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_mode  in  2  00 off, 01 on, 10 blink forever, 11 blink cmd_count times.
- cmd_count  in  CNT_W  burst length for mode 11; ignored otherwise.
- led  out  1  LED drive, registered, 1 = lit.
- busy  out  1  high while in a blink state.
- done  out  1  one-cycle pulse when a mode-11 burst completes.

## Operation
- A command is accepted on a rising clk edge with cmd_valid && cmd_ready. Mode and count are captured at that edge.
- States:
  - S_OFF: led=0.
  - S_ON: led=1.
  - S_BLK_ON: led=1.
  - S_BLK_OFF: led=0.
- cmd_ready is 1 in S_OFF, S_ON, and during mode-10 blinking. It is 0 during a mode-11 burst, so a burst is never aborted except by reset.
- Acceptance transitions from any ready state:
  - 00 goes to S_OFF.
  - 01 goes to S_ON.
  - 10 goes to S_BLK_ON.
  - 11 with count ≥ 1 goes to S_BLK_ON with remaining = count.
  - 11 with count = 0 goes to S_OFF, and done pulses the next cycle.
- Each acceptance clears the prescaler and phase counter, so a re-issued 10 during blinking restarts a fresh ON phase.
- Blink sequencing:
  - S_BLK_ON runs ON_TICKS ticks, then goes to S_BLK_OFF.
  - S_BLK_OFF runs OFF_TICKS ticks. In mode 10 it then returns to S_BLK_ON.
  - In mode 11, remaining decrements at the end of each OFF phase. When it reaches 0, the block goes to S_OFF and pulses done.
- busy = 1 exactly in S_BLK_ON and S_BLK_OFF.
- Accepting 00 or 01 while idle in the same state is legal. It has no visible effect.

## Timing
- Reset values: led=0, busy=0, done=0, cmd_ready=1, state S_OFF, all counters 0.
- Reset mid-burst aborts immediately and asynchronously to the reset values. No done pulse is produced.
- Latency: led reflects an accepted command on the first clk edge after acceptance (one-cycle latency). busy follows the same latency.
- The prescaler counts 0..TICK_DIV-1 and emits a tick at TICK_DIV-1.
- The ON phase lasts exactly ON_TICKS×TICK_DIV cycles of led=1. The OFF phase lasts exactly OFF_TICKS×TICK_DIV cycles.
- Burst end, on the edge that ends the Nth OFF phase:
  - state moves to S_OFF.
  - done=1 for that one cycle.
  - cmd_ready=1 from that same cycle.
  - busy=0 from that same cycle.
- A command can be accepted in the done cycle.
- Count-0 burst: done pulses in the cycle after acceptance. led stays 0 and busy stays 0.
- Phase counter width: clog2(max(ON_TICKS, OFF_TICKS)+1). Remaining counter width: CNT_W. Counters never wrap.

## Structure
- Shared package led_pkg holds:
  - mode encodings MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST;
  - the state enum type;
  - the default tick constant.
- Sub-module tick_prescaler contains:
  - parameter TICK_DIV;
  - ports clk, reset, clr, tick;
  - a free-running divider with synchronous clear.
- The top contains the FSM, the phase counter, the remaining counter, and the output registers.

## Test plan
Bench parameters: TICK_DIV=4, ON_TICKS=3, OFF_TICKS=2, so ON = 12 cycles and OFF = 8 cycles.
- Reset, then idle: led=0, cmd_ready=1, busy=0, done=0. Assert reset mid-burst: all outputs return to reset values immediately, and no done follows.
- Command 01, then 00: led=1 one cycle after the first acceptance and stays high. led=0 one cycle after 00 is accepted.
- Command 10: led alternates 12 cycles high, 8 low, for at least 3 periods. cmd_ready stays 1. Issue 00 mid-ON: led=0 on the next cycle and busy=0.
- Command 11 with count=3:
  - expect exactly 3 high pulses of 12 cycles each;
  - cmd_ready=0 throughout, and a cmd_valid pulsed during the burst is not accepted;
  - done=1 for one cycle, 60 cycles after the acceptance edge, with cmd_ready=1 in that cycle.
- Command 11 with count=0: done pulses in the next cycle, led stays 0, busy stays 0.
- Back-to-back: command 10 accepted in the same cycle as a burst's done pulse. Blinking starts with a full 12-cycle ON phase.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED blinker slice.
// Holds the command mode encodings, the controller state type and the
// default prescaler divide (1 ms ticks from a 50 MHz clock).

package led_pkg;

  // cmd_mode encodings
  localparam logic [1:0] MODE_OFF   = 2'b00;  // steady dark
  localparam logic [1:0] MODE_ON    = 2'b01;  // steady lit
  localparam logic [1:0] MODE_BLINK = 2'b10;  // blink until told otherwise
  localparam logic [1:0] MODE_BURST = 2'b11;  // blink cmd_count times, then off

  // Controller states; led is lit in S_ON and S_BLK_ON.
  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_ON      = 2'd1,
    S_BLK_ON  = 2'd2,
    S_BLK_OFF = 2'd3
  } state_t;

  // clk cycles per tick at 50 MHz for a 1 ms tick
  localparam int DEFAULT_TICK_DIV = 50000;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running clock divider producing a one-cycle tick.
// Ports: clk, reset (async, active-high), clr (sync clear of the divider),
//        tick (high during the cycle the divider sits at TICK_DIV-1).

module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // tick is decoded from the registered count, so it is glitch-free and
  // lines up with the TICK_DIV-th cycle after a clear.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blinker.sv
// led_blinker: command-driven LED controller (off / on / blink / N-blink burst).
// Ports: clk, reset (async, active-high); cmd_valid/cmd_ready handshake with
//        cmd_mode and cmd_count; registered outputs led, busy, done.
//
// All outputs are registered from the next-state decode, so they change on the
// edge that accepts a command or ends a phase (one-cycle command latency).
// cmd_ready drops only for a counted burst, which therefore can only be
// stopped by reset.

module led_blinker
  import led_pkg::*;
#(
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int ON_TICKS  = 250,
  parameter int OFF_TICKS = 250,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             led,
  output logic             busy,
  output logic             done
);

  // Phase counter must hold values up to the longer of the two phases.
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;

  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;   // ticks elapsed in current phase
  logic [CNT_W-1:0] rem_q,   rem_d;     // blinks left in a counted burst
  logic             burst_q, burst_d;   // current blinking is a counted burst
  logic             led_q,   led_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             rdy_q,   rdy_d;

  logic accept;
  logic tick;

  assign accept = cmd_valid && rdy_q;

  // Acceptance clears the divider so a new blink always starts with a full
  // ON phase, regardless of where the free-running divider was.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .tick  (tick)
  );

  // Next-state decode. An accepted command takes priority over a tick that
  // happens to land in the same cycle.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    burst_d = burst_q;
    done_d  = 1'b0;

    if (accept) begin
      phase_d = '0;
      rem_d   = '0;
      burst_d = 1'b0;
      case (cmd_mode)
        MODE_OFF:   state_d = S_OFF;
        MODE_ON:    state_d = S_ON;
        MODE_BLINK: state_d = S_BLK_ON;
        MODE_BURST: begin
          if (cmd_count != '0) begin
            state_d = S_BLK_ON;
            rem_d   = cmd_count;
            burst_d = 1'b1;
          end else begin
            // Empty burst completes immediately without lighting the LED.
            state_d = S_OFF;
            done_d  = 1'b1;
          end
        end
        default:    state_d = S_OFF;
      endcase
    end else if (tick) begin
      case (state_q)
        S_BLK_ON: begin
          if (phase_q == ON_LAST) begin
            state_d = S_BLK_OFF;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        S_BLK_OFF: begin
          if (phase_q == OFF_LAST) begin
            phase_d = '0;
            if (burst_q && (rem_q == CNT_W'(1))) begin
              // End of the last OFF phase: burst complete.
              state_d = S_OFF;
              rem_d   = '0;
              burst_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_BLK_ON;
              if (burst_q) begin
                rem_d = rem_q - CNT_W'(1);
              end
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        default: ;  // steady states ignore ticks
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered values land on
  // the same edge as the state change.
  always_comb begin
    led_d  = (state_d == S_ON) || (state_d == S_BLK_ON);
    busy_d = (state_d == S_BLK_ON) || (state_d == S_BLK_OFF);
    rdy_d  = !(busy_d && burst_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_OFF;
      phase_q <= '0;
      rem_q   <= '0;
      burst_q <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = rdy_q;

endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: directed bench for led_blinker with TICK_DIV=4, ON_TICKS=3,
// OFF_TICKS=2, giving 12-cycle ON and 8-cycle OFF phases (20-cycle period).
// Outputs are sampled 1 time unit after each rising edge.

module tb_led_blinker;

  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int CNT_W     = 4;
  localparam int ON_CYC    = 12;
  localparam int PER_CYC   = 20;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic             led;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_blinker #(
    .TICK_DIV  (TICK_DIV),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_count (cmd_count),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e_led, input logic e_busy,
                            input logic e_done, input logic e_rdy);
    check({tag, "/led"},  32'(led),       32'(e_led));
    check({tag, "/busy"}, 32'(busy),      32'(e_busy));
    check({tag, "/done"}, 32'(done),      32'(e_done));
    check({tag, "/rdy"},  32'(cmd_ready), 32'(e_rdy));
  endtask

  // Present one command for a single cycle; returns just after the accepting edge.
  task automatic send(input logic [1:0] mode, input logic [CNT_W-1:0] count);
    check("send_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_count = count;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int rises;
    logic prev_led;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = M_OFF;
    cmd_count = '0;
    #1 reset  = 1'b1;
    #6;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    repeat (3) step();
    expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Steady on, then off.
    send(M_ON, '0);
    expect_out("on_lat", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("on_hold%0d", i), 32'(led), 32'd1);
    end
    send(M_OFF, '0);
    expect_out("off_lat", 1'b0, 1'b0, 1'b0, 1'b1);

    // Continuous blink for >3 periods, then stop mid-ON.
    send(M_BLINK, '0);
    for (int k = 0; k <= 64; k++) begin
      expect_out($sformatf("blink k=%0d", k), 1'((k % PER_CYC) < ON_CYC), 1'b1, 1'b0, 1'b1);
      if (k < 64) step();
    end
    send(M_OFF, '0);
    expect_out("blink_stop", 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Burst of 3 with an ignored command mid-burst and a blink command
    // presented in the done cycle.
    send(M_BURST, 4'd3);
    rises    = 0;
    prev_led = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      expect_out($sformatf("burst3 k=%0d", k),
                 1'((k < 60) && ((k % PER_CYC) < ON_CYC)),
                 1'(k < 60), 1'(k == 60), 1'(k >= 60));
      if (led && !prev_led) rises++;
      prev_led  = led;
      cmd_valid = (k == 5) || (k == 60);
      cmd_mode  = (k == 60) ? M_BLINK : M_OFF;
      step();
    end
    cmd_valid = 1'b0;
    check("burst3_pulses", 32'(rises), 32'd3);
    for (int j = 0; j <= 20; j++) begin
      expect_out($sformatf("b2b j=%0d", j), 1'((j % PER_CYC) < ON_CYC), 1'b1, 1'b0, 1'b1);
      if (j < 20) step();
    end
    send(M_OFF, '0);
    expect_out("b2b_stop", 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Empty burst.
    send(M_BURST, 4'd0);
    expect_out("burst0", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    expect_out("burst0_after", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a burst: immediate, and no late done.
    send(M_BURST, 4'd5);
    repeat (7) step();
    expect_out("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    expect_out("rst_async", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 110; k++) begin
      expect_out($sformatf("post_rst k=%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
